// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard control, redirect targets, instruction memory and IF/ID outputs.
// master = the fetch stage, slave = hazard unit / ID stage / instruction memory side.
interface instruction_fetch_stage_if;
  logic        Stall;
  logic        Flush;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] JrTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] PC;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport master (
    input  Stall, Flush, PCSrc, BranchTarget, JumpTarget, JrTarget, IMemData,
    output IMemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           FetchCount, StallCount, FlushCount
  );

  modport slave (
    output Stall, Flush, PCSrc, BranchTarget, JumpTarget, JrTarget, IMemData,
    input  IMemAddr, PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           FetchCount, StallCount, FlushCount
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, next-PC mux, IF/ID pipeline register.
// Optional performance counters are built when IF_STAGE_PERF_CNT_EN is defined.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input logic                    clk,
  input logic                    reset,
  instruction_fetch_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    unique case (bus.PCSrc)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = bus.BranchTarget;
      2'b10: next_pc = bus.JumpTarget;
      2'b11: next_pc = bus.JrTarget;
      default: next_pc = pc_plus4;
    endcase
    // Misaligned targets are silently word-aligned; no address exception exists.
    next_pc[1:0] = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_WORD;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (!bus.Stall) begin
      pc <= next_pc;
      if (bus.Flush) begin
        ifid_instr    <= NOP_WORD;
        ifid_pc_plus4 <= 32'd0;
        ifid_valid    <= 1'b0;
      end else begin
        ifid_instr    <= bus.IMemData;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid    <= 1'b1;
      end
    end
  end

  assign bus.IMemAddr         = pc;
  assign bus.PC               = pc;
  assign bus.IFID_Instruction = ifid_instr;
  assign bus.IFID_PCPlus4     = ifid_pc_plus4;
  assign bus.IFID_Valid       = ifid_valid;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (bus.Stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else if (bus.Flush) begin
      flush_cnt <= flush_cnt + 32'd1;
    end else begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign bus.FetchCount = fetch_cnt;
  assign bus.StallCount = stall_cnt;
  assign bus.FlushCount = flush_cnt;
`else
  assign bus.FetchCount = 32'd0;
  assign bus.StallCount = 32'd0;
  assign bus.FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: reference model feeds a scoreboard checked every cycle,
// plus scenario tasks with fixed expected values.
module tb_instruction_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam logic [31:0] NOP_WORD = 32'h00000000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] sc;
    logic [31:0] flc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [31:0] m_pc = RESET_PC, m_instr = NOP_WORD, m_pp4 = 32'd0;
  logic        m_valid = 1'b0;
  logic [31:0] m_fc = 32'd0, m_sc = 32'd0, m_flc = 32'd0;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h00000000: imem = 32'h20040003;
      32'h00000004: imem = 32'h0c000003;
      default:      imem = {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  assign bus.IMemData = imem(bus.IMemAddr);

  // One cycle: drive at negedge, advance the reference model, push expectation.
  task automatic step(input logic rst_i, input logic stall_i, input logic flush_i,
                      input logic [1:0] src, input logic [31:0] tgt);
    logic [31:0] nxt;
    exp_t e;
    @(negedge clk);
    reset            = rst_i;
    bus.Stall        = stall_i;
    bus.Flush        = flush_i;
    bus.PCSrc        = src;
    bus.BranchTarget = (src == 2'b01) ? tgt : 32'h00000B00;
    bus.JumpTarget   = (src == 2'b10) ? tgt : 32'h00000C00;
    bus.JrTarget     = (src == 2'b11) ? tgt : 32'h00000D00;
    if (rst_i) begin
      m_pc = RESET_PC; m_instr = NOP_WORD; m_pp4 = 32'd0; m_valid = 1'b0;
      m_fc = 32'd0; m_sc = 32'd0; m_flc = 32'd0;
    end else if (stall_i) begin
      m_sc = m_sc + 32'd1;
    end else begin
      case (src)
        2'b01:   nxt = tgt;
        2'b10:   nxt = tgt;
        2'b11:   nxt = tgt;
        default: nxt = m_pc + 32'd4;
      endcase
      nxt = nxt & 32'hFFFFFFFC;
      if (flush_i) begin
        m_instr = NOP_WORD; m_pp4 = 32'd0; m_valid = 1'b0; m_flc = m_flc + 32'd1;
      end else begin
        m_instr = imem(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_fc = m_fc + 32'd1;
      end
      m_pc = nxt;
    end
    e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid;
`ifdef IF_STAGE_PERF_CNT_EN
    e.fc = m_fc; e.sc = m_sc; e.flc = m_flc;
`else
    e.fc = 32'd0; e.sc = 32'd0; e.flc = 32'd0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compares DUT state after every edge against the model.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.PC !== e.pc || bus.IMemAddr !== e.pc) begin
        failures++;
        $display("FAIL sb_pc: PC=%h IMemAddr=%h expected %h", bus.PC, bus.IMemAddr, e.pc);
      end
      checks++;
      if (bus.IFID_Instruction !== e.instr || bus.IFID_PCPlus4 !== e.pp4 || bus.IFID_Valid !== e.valid) begin
        failures++;
        $display("FAIL sb_ifid: instr=%h pp4=%h valid=%b expected %h %h %b",
                 bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid, e.instr, e.pp4, e.valid);
      end
      checks++;
      if (bus.FetchCount !== e.fc || bus.StallCount !== e.sc || bus.FlushCount !== e.flc) begin
        failures++;
        $display("FAIL sb_cnt: fetch=%0d stall=%0d flush=%0d expected %0d %0d %0d",
                 bus.FetchCount, bus.StallCount, bus.FlushCount, e.fc, e.sc, e.flc);
      end
    end
  end

  task automatic test_reset_sequential();
    step(1, 0, 0, 2'b00, 0);
    step(1, 0, 0, 2'b00, 0);
    checks++;
    if (bus.PC !== 32'h0 || bus.IFID_Valid !== 1'b0 || bus.IFID_Instruction !== NOP_WORD) begin
      failures++;
      $display("FAIL reset_state: PC=%h valid=%b instr=%h expected 0 0 %h",
               bus.PC, bus.IFID_Valid, bus.IFID_Instruction, NOP_WORD);
    end
    step(0, 0, 0, 2'b00, 0);
    checks++;
    if (bus.IMemAddr !== 32'h4 || bus.IFID_Instruction !== 32'h20040003 ||
        bus.IFID_PCPlus4 !== 32'h4 || bus.IFID_Valid !== 1'b1) begin
      failures++;
      $display("FAIL seq_first: addr=%h instr=%h pp4=%h valid=%b expected 4 20040003 4 1",
               bus.IMemAddr, bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid);
    end
    step(0, 0, 0, 2'b00, 0);
    checks++;
    if (bus.IMemAddr !== 32'h8 || bus.IFID_Instruction !== 32'h0c000003 || bus.IFID_PCPlus4 !== 32'h8) begin
      failures++;
      $display("FAIL seq_second: addr=%h instr=%h pp4=%h expected 8 0c000003 8",
               bus.IMemAddr, bus.IFID_Instruction, bus.IFID_PCPlus4);
    end
  endtask

  task automatic test_branch_flush();
    while (m_pc != 32'h1C) step(0, 0, 0, 2'b00, 0);
    step(0, 0, 1, 2'b01, 32'h2C);
    checks++;
    if (bus.PC !== 32'h2C || bus.IFID_Instruction !== NOP_WORD || bus.IFID_Valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_flush: PC=%h instr=%h valid=%b expected 2c %h 0",
               bus.PC, bus.IFID_Instruction, bus.IFID_Valid, NOP_WORD);
    end
    step(0, 0, 0, 2'b00, 0);
    checks++;
    if (bus.IFID_Instruction !== imem(32'h2C) || bus.IFID_PCPlus4 !== 32'h30 || bus.IFID_Valid !== 1'b1) begin
      failures++;
      $display("FAIL branch_target_fetch: instr=%h pp4=%h valid=%b expected %h 30 1",
               bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid, imem(32'h2C));
    end
  endtask

  task automatic test_stall_hold();
    step(1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 2'b10, 32'h100);
      checks++;
      if (bus.PC !== 32'h10 || bus.IFID_Instruction !== imem(32'hC) ||
          bus.IFID_PCPlus4 !== 32'h10 || bus.IFID_Valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: PC=%h instr=%h pp4=%h valid=%b expected 10 %h 10 1",
                 i, bus.PC, bus.IFID_Instruction, bus.IFID_PCPlus4, bus.IFID_Valid, imem(32'hC));
      end
    end
    step(0, 0, 1, 2'b10, 32'h100);
    checks++;
    if (bus.PC !== 32'h100 || bus.IFID_Valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: PC=%h valid=%b expected 100 0", bus.PC, bus.IFID_Valid);
    end
  endtask

  task automatic test_jr_align_wrap();
    step(0, 0, 0, 2'b11, 32'h00000023);
    checks++;
    if (bus.PC !== 32'h20 || bus.IFID_Valid !== 1'b1) begin
      failures++;
      $display("FAIL jr_align: PC=%h valid=%b expected 20 1", bus.PC, bus.IFID_Valid);
    end
    step(0, 0, 1, 2'b10, 32'hFFFFFFFC);
    step(0, 0, 0, 2'b00, 0);
    checks++;
    if (bus.PC !== 32'h0 || bus.IFID_PCPlus4 !== 32'h0 || bus.IFID_Valid !== 1'b1) begin
      failures++;
      $display("FAIL pc_wrap: PC=%h pp4=%h valid=%b expected 0 0 1",
               bus.PC, bus.IFID_PCPlus4, bus.IFID_Valid);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 2'b01, 32'h200);
    step(0, 0, 0, 2'b10, 32'h300);
    step(0, 0, 0, 2'b11, 32'h401);
    checks++;
    if (bus.PC !== 32'h400 || bus.IFID_PCPlus4 !== 32'h304) begin
      failures++;
      $display("FAIL back_to_back: PC=%h pp4=%h expected 400 304", bus.PC, bus.IFID_PCPlus4);
    end
  endtask

  task automatic test_reset_mid_stall();
    step(0, 0, 1, 2'b10, 32'h40);
    step(0, 1, 0, 2'b00, 0);
    step(1, 1, 1, 2'b01, 32'h80);
    checks++;
    if (bus.PC !== RESET_PC || bus.IFID_Valid !== 1'b0 || bus.IFID_Instruction !== NOP_WORD) begin
      failures++;
      $display("FAIL reset_mid_stall: PC=%h valid=%b instr=%h expected %h 0 %h",
               bus.PC, bus.IFID_Valid, bus.IFID_Instruction, RESET_PC, NOP_WORD);
    end
    step(0, 0, 0, 2'b00, 0);
    checks++;
    if (bus.IFID_PCPlus4 !== RESET_PC + 32'd4 || bus.IFID_Instruction !== 32'h20040003) begin
      failures++;
      $display("FAIL post_reset_fetch: pp4=%h instr=%h expected 4 20040003",
               bus.IFID_PCPlus4, bus.IFID_Instruction);
    end
  endtask

  task automatic test_perf_counters();
    logic [31:0] ef, es, el;
    step(1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 2'b00, 0);
    step(0, 0, 1, 2'b00, 0);
`ifdef IF_STAGE_PERF_CNT_EN
    ef = 32'd5; es = 32'd2; el = 32'd1;
`else
    ef = 32'd0; es = 32'd0; el = 32'd0;
`endif
    checks++;
    if (bus.FetchCount !== ef || bus.StallCount !== es || bus.FlushCount !== el) begin
      failures++;
      $display("FAIL perf_counters: fetch=%0d stall=%0d flush=%0d expected %0d %0d %0d",
               bus.FetchCount, bus.StallCount, bus.FlushCount, ef, es, el);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.PCSrc = 2'b00;
    bus.BranchTarget = 32'h0; bus.JumpTarget = 32'h0; bus.JrTarget = 32'h0;
    test_reset_sequential();
    test_branch_flush();
    test_stall_hold();
    test_jr_align_wrap();
    test_back_to_back();
    test_reset_mid_stall();
    test_perf_counters();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
